// File: rtl/vector_op_sequencer.sv
// ============================================================================
// Module   : vector_op_sequencer
// Purpose  : Element-wise vector op sequencer: RF read, 1-deep operand stage,
//            ALU writeback. Optional host write port under VSEQ_HOST_WR_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vector_op_sequencer #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_ELE    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_vd,
  input  logic [ADDR_WIDTH-1:0] cmd_vs1,
  input  logic [ADDR_WIDTH-1:0] cmd_vs2,
  input  logic [ADDR_WIDTH:0]   cmd_vl,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rf_rAddr1_1,
  output logic [ADDR_WIDTH-1:0] rf_rAddr2_1,
  output logic [ADDR_WIDTH-1:0] rf_rAddr1_2,
  output logic [ADDR_WIDTH-1:0] rf_rAddr2_2,
  input  logic [DATA_WIDTH-1:0] rf_rData1,
  input  logic [DATA_WIDTH-1:0] rf_rData2,
  output logic [ADDR_WIDTH-1:0] rf_wAddr1,
  output logic [ADDR_WIDTH-1:0] rf_wAddr2,
  output logic [DATA_WIDTH-1:0] rf_wData,
  output logic                  rf_wEnable,
`ifdef VSEQ_HOST_WR_EN
  input  logic                  host_wr_valid,
  output logic                  host_wr_ready,
  input  logic [ADDR_WIDTH-1:0] host_wr_reg,
  input  logic [ADDR_WIDTH-1:0] host_wr_ele,
  input  logic [DATA_WIDTH-1:0] host_wr_data,
`endif
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_y
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH+1)'(NUM_ELE);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] vd_q, vd_d;
  logic [ADDR_WIDTH-1:0] vs1_q, vs1_d;
  logic [ADDR_WIDTH-1:0] vs2_q, vs2_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  opv_q, opv_d;
  logic [DATA_WIDTH-1:0] opa_q, opa_d;
  logic [DATA_WIDTH-1:0] opb_q, opb_d;
  logic [ADDR_WIDTH-1:0] opidx_q, opidx_d;

  logic [ADDR_WIDTH:0]   eff_len;
  logic                  last_issue;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      vd_q    <= '0;
      vs1_q   <= '0;
      vs2_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      opv_q   <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      opidx_q <= '0;
    end else begin
      state_q <= state_d;
      vd_q    <= vd_d;
      vs1_q   <= vs1_d;
      vs2_q   <= vs2_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      opv_q   <= opv_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      opidx_q <= opidx_d;
    end
  end

  assign eff_len    = (cmd_vl > MAX_LEN) ? MAX_LEN : cmd_vl;
  assign last_issue = ({1'b0, idx_q} == (len_q - (ADDR_WIDTH+1)'(1)));

  always_comb begin
    state_d = state_q;
    vd_d    = vd_q;
    vs1_d   = vs1_q;
    vs2_d   = vs2_q;
    len_d   = len_q;
    idx_d   = idx_q;
    opv_d   = 1'b0;
    opa_d   = opa_q;
    opb_d   = opb_q;
    opidx_d = opidx_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          vd_d    = cmd_vd;
          vs1_d   = cmd_vs1;
          vs2_d   = cmd_vs2;
          len_d   = eff_len;
          idx_d   = '0;
          state_d = (eff_len == '0) ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        // Element idx_q is read this cycle and written next cycle.
        opv_d   = 1'b1;
        opa_d   = rf_rData1;
        opb_d   = rf_rData2;
        opidx_d = idx_q;
        idx_d   = idx_q + ADDR_WIDTH'(1);
        if (last_issue) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    cmd_ready   = (state_q == ST_IDLE) && !reset;
    busy        = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && !reset;
    done        = (state_q == ST_DRAIN) && !reset;
    rf_rAddr1_1 = (state_q == ST_RUN) ? vs1_q : '0;
    rf_rAddr2_1 = (state_q == ST_RUN) ? idx_q : '0;
    rf_rAddr1_2 = (state_q == ST_RUN) ? vs2_q : '0;
    rf_rAddr2_2 = (state_q == ST_RUN) ? idx_q : '0;
    alu_a       = opa_q;
    alu_b       = opb_q;
  end

`ifdef VSEQ_HOST_WR_EN
  logic host_wr_fire;

  // The host only gets the port in cycles with no staged sequencer write.
  assign host_wr_ready = !opv_q && !reset;
  assign host_wr_fire  = host_wr_valid && host_wr_ready;

  always_comb begin
    rf_wEnable = 1'b0;
    rf_wAddr1  = '0;
    rf_wAddr2  = '0;
    rf_wData   = '0;
    if (opv_q) begin
      rf_wEnable = 1'b1;
      rf_wAddr1  = vd_q;
      rf_wAddr2  = opidx_q;
      rf_wData   = alu_y;
    end else if (host_wr_fire) begin
      rf_wEnable = 1'b1;
      rf_wAddr1  = host_wr_reg;
      rf_wAddr2  = host_wr_ele;
      rf_wData   = host_wr_data;
    end
  end
`else
  always_comb begin
    rf_wEnable = opv_q;
    rf_wAddr1  = opv_q ? vd_q    : '0;
    rf_wAddr2  = opv_q ? opidx_q : '0;
    rf_wData   = opv_q ? alu_y   : '0;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_vector_op_sequencer.sv
// ============================================================================
// Module   : tb_vector_op_sequencer
// Purpose  : Directed self-checking bench for vector_op_sequencer (RF + add ALU
//            model); covers host write port when VSEQ_HOST_WR_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vector_op_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_vd, cmd_vs1, cmd_vs2;
  logic [5:0]  cmd_vl;
  logic        busy, done;
  logic [4:0]  rf_rAddr1_1, rf_rAddr2_1, rf_rAddr1_2, rf_rAddr2_2;
  logic [31:0] rf_rData1, rf_rData2;
  logic [4:0]  rf_wAddr1, rf_wAddr2;
  logic [31:0] rf_wData;
  logic        rf_wEnable;
  logic [31:0] alu_a, alu_b, alu_y;
`ifdef VSEQ_HOST_WR_EN
  logic        host_wr_valid;
  logic        host_wr_ready;
  logic [4:0]  host_wr_reg, host_wr_ele;
  logic [31:0] host_wr_data;
`endif

  logic        ld_we;
  logic [4:0]  ld_reg, ld_ele;
  logic [31:0] ld_data;

  logic [31:0] rf [32][32];
  int          wcount = 0;
  int          checks = 0;
  int          failures = 0;

  vector_op_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_vd      (cmd_vd),
    .cmd_vs1     (cmd_vs1),
    .cmd_vs2     (cmd_vs2),
    .cmd_vl      (cmd_vl),
    .busy        (busy),
    .done        (done),
    .rf_rAddr1_1 (rf_rAddr1_1),
    .rf_rAddr2_1 (rf_rAddr2_1),
    .rf_rAddr1_2 (rf_rAddr1_2),
    .rf_rAddr2_2 (rf_rAddr2_2),
    .rf_rData1   (rf_rData1),
    .rf_rData2   (rf_rData2),
    .rf_wAddr1   (rf_wAddr1),
    .rf_wAddr2   (rf_wAddr2),
    .rf_wData    (rf_wData),
    .rf_wEnable  (rf_wEnable),
`ifdef VSEQ_HOST_WR_EN
    .host_wr_valid (host_wr_valid),
    .host_wr_ready (host_wr_ready),
    .host_wr_reg   (host_wr_reg),
    .host_wr_ele   (host_wr_ele),
    .host_wr_data  (host_wr_data),
`endif
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_y       (alu_y)
  );

  always #5 clk = ~clk;

  assign rf_rData1 = rf[rf_rAddr1_1][rf_rAddr2_1];
  assign rf_rData2 = rf[rf_rAddr1_2][rf_rAddr2_2];
  assign alu_y     = alu_a + alu_b;

  // Register file model; the loader port is only used while the DUT is idle.
  always @(posedge clk) begin
    if (rf_wEnable) begin
      rf[rf_wAddr1][rf_wAddr2] <= rf_wData;
      wcount <= wcount + 1;
    end else if (ld_we) begin
      rf[ld_reg][ld_ele] <= ld_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [4:0] r, input logic [4:0] e, input logic [31:0] d);
    @(negedge clk);
    ld_we = 1'b1; ld_reg = r; ld_ele = e; ld_data = d;
    @(posedge clk); #1;
    ld_we = 1'b0;
  endtask

  task automatic run_cmd(input string tag, input logic [4:0] vd, input logic [4:0] vs1,
                         input logic [4:0] vs2, input logic [5:0] vl,
                         input int exp_done, input int exp_writes);
    int n;
    int snap;
    bit busy_ok;
    @(negedge clk);
    check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_vd = vd; cmd_vs1 = vs1; cmd_vs2 = vs2; cmd_vl = vl;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    snap = wcount;
    n = 0;
    busy_ok = 1'b1;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (!busy) busy_ok = 1'b0;
      if (done) break;
    end
    check({tag, "_done_cycle"}, n, exp_done);
    check({tag, "_busy"}, 32'(busy_ok), 32'd1);
    @(posedge clk); #1;
    check({tag, "_writes"}, wcount - snap, exp_writes);
    @(negedge clk);
    check({tag, "_ready_after"}, 32'(cmd_ready), 32'd1);
    check({tag, "_done_1cyc"}, 32'(done), 32'd0);
  endtask

  initial begin
    int snap;
    bit dseen;
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_vd = '0; cmd_vs1 = '0; cmd_vs2 = '0; cmd_vl = '0;
    ld_we = 1'b0; ld_reg = '0; ld_ele = '0; ld_data = '0;
`ifdef VSEQ_HOST_WR_EN
    host_wr_valid = 1'b0; host_wr_reg = '0; host_wr_ele = '0; host_wr_data = '0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wen", 32'(rf_wEnable), 32'd0);
    check("rst_raddr", 32'({rf_rAddr1_1, rf_rAddr2_1, rf_rAddr1_2, rf_rAddr2_2}), 32'd0);
    check("rst_alu", alu_a | alu_b, 32'd0);
`ifdef VSEQ_HOST_WR_EN
    check("rst_host_ready", 32'(host_wr_ready), 32'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(cmd_ready), 32'd1);

    for (int e = 0; e < 32; e++) begin
      load(5'd1, 5'(e), 32'(e + 1));
      load(5'd2, 5'(e), 32'(10 * (e + 1)));
      load(5'd3, 5'(e), 32'hAAAA_0000 + 32'(e));
      load(5'd4, 5'(e), 32'hDEAD_0000 + 32'(e));
      load(5'd5, 5'(e), 32'(100 + e));
    end
    load(5'd7, 5'd0, 32'h0000_0077);

    // v3 = v1 + v2, four elements
    run_cmd("add4", 5'd3, 5'd1, 5'd2, 6'd4, 5, 4);
    check("add4_e0", rf[3][0], 32'd11);
    check("add4_e1", rf[3][1], 32'd22);
    check("add4_e2", rf[3][2], 32'd33);
    check("add4_e3", rf[3][3], 32'd44);
    check("add4_e4_untouched", rf[3][4], 32'hAAAA_0004);

    // zero length: no writes, done right after accept
    run_cmd("vl0", 5'd7, 5'd1, 5'd2, 6'd0, 1, 0);
    check("vl0_untouched", rf[7][0], 32'h0000_0077);

    // length clamped to 32
    run_cmd("vl40", 5'd6, 5'd1, 5'd2, 6'd40, 33, 32);
    check("vl40_e0", rf[6][0], 32'd11);
    check("vl40_e31", rf[6][31], 32'd352);

    // in-place: v5 = v5 + v2
    run_cmd("inplace", 5'd5, 5'd5, 5'd2, 6'd32, 33, 32);
    for (int e = 0; e < 32; e++) begin
      check($sformatf("inplace_e%0d", e), rf[5][e], 32'(100 + e + 10 * (e + 1)));
    end

    // reset after the third write of a length-8 command
    @(negedge clk);
    cmd_valid = 1'b1; cmd_vd = 5'd4; cmd_vs1 = 5'd1; cmd_vs2 = 5'd2; cmd_vl = 6'd8;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    snap = wcount;
    dseen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) dseen = 1'b1;
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("abort_writes", wcount - snap, 3);
    check("abort_wen", 32'(rf_wEnable), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(cmd_ready), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_alu", alu_a | alu_b, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_ready_after", 32'(cmd_ready), 32'd1);
    check("abort_no_done", 32'(dseen | done), 32'd0);
    check("abort_e2", rf[4][2], 32'd33);
    for (int e = 3; e < 8; e++) begin
      check($sformatf("abort_e%0d_untouched", e), rf[4][e], 32'hDEAD_0000 + 32'(e));
    end

`ifdef VSEQ_HOST_WR_EN
    // host write held valid while the sequencer owns the write port
    @(negedge clk);
    cmd_valid = 1'b1; cmd_vd = 5'd3; cmd_vs1 = 5'd1; cmd_vs2 = 5'd2; cmd_vl = 6'd4;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    host_wr_valid = 1'b1; host_wr_reg = 5'd7; host_wr_ele = 5'd9; host_wr_data = 32'h1234;
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      check($sformatf("host_blocked_c%0d", c), 32'({host_wr_ready, rf_wEnable, rf_wAddr1}),
            32'({1'b0, 1'b1, 5'd3}));
    end
    @(negedge clk);
    check("host_free_cycle", 32'({host_wr_ready, rf_wEnable, rf_wAddr1, rf_wAddr2}),
          32'({1'b1, 1'b1, 5'd7, 5'd9}));
    @(posedge clk); #1;
    host_wr_valid = 1'b0;
    check("host_data", rf[7][9], 32'h1234);
    check("host_seq_e3", rf[3][3], 32'd44);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
